mem_arbiter: RTL

- Two-requester round-robin arbiter that shares one single-port synchronous memory (active-low chip select/read/write, registered read address, read data valid one cycle after the read strobe).
- Each requester issues one transaction at a time: a req/ack handshake with a write-enable, address and write data.
- The arbiter sequences the memory strobes, captures read data, and returns it with a one-cycle ack pulse.
- Sits between the CPU-side and DMA-side masters and the memory block.

---
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous memory.
// Each transaction runs IDLE -> ISSUE -> RESP -> ACK, so it takes at least 4 cycles.
module mem_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 4
) (
  input  logic                     iClk,
  input  logic                     iReset_n,
  input  logic                     iReq0,
  input  logic                     iReq1,
  input  logic                     iWe0,
  input  logic                     iWe1,
  input  logic [ADDRESS_WIDTH-1:0] iAddr0,
  input  logic [ADDRESS_WIDTH-1:0] iAddr1,
  input  logic [DATA_WIDTH-1:0]    iWrData0,
  input  logic [DATA_WIDTH-1:0]    iWrData1,
  output logic                     oAck0,
  output logic                     oAck1,
  output logic [DATA_WIDTH-1:0]    oRdData,
  output logic                     oGrant,
  output logic                     oBusy,
  output logic                     oMemChipSelect_n,
  output logic                     oMemRead_n,
  output logic                     oMemWrite_n,
  output logic [ADDRESS_WIDTH-1:0] oMemAddress,
  output logic [DATA_WIDTH-1:0]    oMemData,
  input  logic [DATA_WIDTH-1:0]    iMemData
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP, ACK} state_e;

  state_e                   state_q, state_d;
  logic                     ptr_q, ptr_d;
  logic                     grant_q, grant_d;
  logic                     busy_q, busy_d;
  logic                     we_q, we_d;
  logic                     cs_n_q, cs_n_d;
  logic                     rd_n_q, rd_n_d;
  logic                     wr_n_q, wr_n_d;
  logic                     ack0_q, ack0_d;
  logic                     ack1_q, ack1_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
  logic                     win;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    we_d    = we_q;
    cs_n_d  = cs_n_q;
    rd_n_d  = rd_n_q;
    wr_n_d  = wr_n_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    win     = 1'b0;
    unique case (state_q)
      IDLE: if (iReq0 || iReq1) begin
        // pointer-favoured requester wins if requesting, otherwise the other one
        win     = ptr_q ? iReq1 : ~iReq0;
        grant_d = win;
        busy_d  = 1'b1;
        we_d    = win ? iWe1 : iWe0;
        addr_d  = win ? iAddr1 : iAddr0;
        wdata_d = win ? iWrData1 : iWrData0;
        cs_n_d  = 1'b0;
        wr_n_d  = ~we_d;
        rd_n_d  = we_d;
        state_d = ISSUE;
      end
      ISSUE: begin
        cs_n_d  = 1'b1;
        rd_n_d  = 1'b1;
        wr_n_d  = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (!we_q) rdata_d = iMemData;
        ack0_d  = ~grant_q;
        ack1_d  = grant_q;
        ptr_d   = ~grant_q;
        state_d = ACK;
      end
      ACK: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      grant_q <= 1'b0;
      busy_q  <= 1'b0;
      we_q    <= 1'b0;
      cs_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      we_q    <= we_d;
      cs_n_q  <= cs_n_d;
      rd_n_q  <= rd_n_d;
      wr_n_q  <= wr_n_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign oAck0            = ack0_q;
  assign oAck1            = ack1_q;
  assign oRdData          = rdata_q;
  assign oGrant           = grant_q;
  assign oBusy            = busy_q;
  assign oMemChipSelect_n = cs_n_q;
  assign oMemRead_n       = rd_n_q;
  assign oMemWrite_n      = wr_n_q;
  assign oMemAddress      = addr_q;
  assign oMemData         = wdata_q;

endmodule
